clint_timer: RTL and testbench

Core-local interruptor behind the system bus's CLINT window (`CLINT_START`..`CLINT_END`). It holds the RISC-V machine timer (`mtime`), the timer compare register (`mtimecmp`) and the software-interrupt bit (`msip`). It raises `timer_irq` and `soft_irq` to the core and returns read data to the bus on `clint_data_out`. Accesses arrive as the bus's `clint_ren`/`clint_wen` strobes with the full data address.

---
 rtl/clint_timer.sv | 124 ++++++++++++
 tb/tb_clint_timer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_timer.sv
// ---------------------------------------------------------------------------
// clint_timer
//   Core-local interruptor: RISC-V machine timer (mtime), timer compare
//   (mtimecmp) and software-interrupt bit (msip) behind the CLINT bus window.
//
// Ports
//   clk_i        system clock (single domain)
//   rst_ni       asynchronous active-low reset
//   addr_i       full data address; block offset = addr_i - CLINT_START
//   ren_i        read strobe
//   wen_i        write strobe (word writes only)
//   data_in_i    write data
//   data_out_o   combinational read data for the current addr_i
//   timer_irq_o  machine timer interrupt pending (registered mtime >= mtimecmp)
//   soft_irq_o   machine software interrupt pending (msip[0])
// ---------------------------------------------------------------------------
module clint_timer #(
    parameter int unsigned PRESCALE    = 27,
    parameter logic [31:0] CLINT_START = 32'h0200_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] addr_i,
    input  logic        ren_i,
    input  logic        wen_i,
    input  logic [31:0] data_in_i,
    output logic [31:0] data_out_o,
    output logic        timer_irq_o,
    output logic        soft_irq_o
);

    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

    localparam logic [15:0] OFF_MSIP    = 16'h0000;
    localparam logic [15:0] OFF_CMP_LO  = 16'h4000;
    localparam logic [15:0] OFF_CMP_HI  = 16'h4004;
    localparam logic [15:0] OFF_TIME_LO = 16'hBFF8;
    localparam logic [15:0] OFF_TIME_HI = 16'hBFFC;

    logic [15:0] pre_q, pre_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [31:0] snap_q, snap_d;
    logic        msip_q, msip_d;
    logic        irq_q;

    logic [31:0] off_full;
    logic [15:0] off;
    logic        unused_off_hi;
    logic        tick;

    // Only the low 16 offset bits select a register.
    assign off_full      = addr_i - CLINT_START;
    assign off           = off_full[15:0];
    assign unused_off_hi = ^off_full[31:16];

    assign tick = (pre_q == PRE_MAX);

    always_comb begin
        pre_d      = tick ? 16'd0 : pre_q + 16'd1;
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        snap_d     = snap_q;
        msip_d     = msip_q;

        // Reading the low word freezes the high word for a tear-free 64-bit read.
        if (ren_i && off == OFF_TIME_LO)
            snap_d = mtime_q[63:32];

        // A software write to either mtime half takes precedence over the tick.
        if (wen_i && off == OFF_TIME_LO) begin
            mtime_d[31:0] = data_in_i;
        end else if (wen_i && off == OFF_TIME_HI) begin
            mtime_d[63:32] = data_in_i;
            snap_d         = data_in_i;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        if (wen_i) begin
            case (off)
                OFF_MSIP:   msip_d             = data_in_i[0];
                OFF_CMP_LO: mtimecmp_d[31:0]   = data_in_i;
                OFF_CMP_HI: mtimecmp_d[63:32]  = data_in_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pre_q      <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            snap_q     <= '0;
            msip_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            snap_q     <= snap_d;
            msip_q     <= msip_d;
            irq_q      <= (mtime_q >= mtimecmp_q);
        end
    end

    // Read mux ignores ren_i; the bus decides when to capture.
    always_comb begin
        data_out_o = '0;
        case (off)
            OFF_MSIP:    data_out_o = {31'd0, msip_q};
            OFF_CMP_LO:  data_out_o = mtimecmp_q[31:0];
            OFF_CMP_HI:  data_out_o = mtimecmp_q[63:32];
            OFF_TIME_LO: data_out_o = mtime_q[31:0];
            OFF_TIME_HI: data_out_o = snap_q;
            default:     data_out_o = '0;
        endcase
    end

    assign timer_irq_o = irq_q;
    assign soft_irq_o  = msip_q;

endmodule

// File: tb/tb_clint_timer.sv
// ---------------------------------------------------------------------------
// tb_clint_timer
//   Random and directed bus traffic against clint_timer, checked every cycle
//   against a register-level reference model of the CLINT.
// ---------------------------------------------------------------------------
module tb_clint_timer;

    localparam int unsigned P     = 4;
    localparam logic [31:0] START = 32'h0200_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic        ren;
    logic        wen;
    logic [31:0] din;
    logic [31:0] dout;
    logic        tirq;
    logic        sirq;

    int checks = 0;
    int errors = 0;

    // reference model state
    longint unsigned m_time;
    longint unsigned m_cmp;
    logic [31:0]     m_snap;
    logic            m_msip;
    logic            m_irq;
    int              m_pre;

    clint_timer #(.PRESCALE(P), .CLINT_START(START)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .addr_i      (addr),
        .ren_i       (ren),
        .wen_i       (wen),
        .data_in_i   (din),
        .data_out_o  (dout),
        .timer_irq_o (tirq),
        .soft_irq_o  (sirq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] offs(input logic [31:0] a);
        logic [31:0] d;
        d = a - START;
        return d[15:0];
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (offs(a))
            16'h0000: return {31'd0, m_msip};
            16'h4000: return m_cmp[31:0];
            16'h4004: return m_cmp[63:32];
            16'hBFF8: return m_time[31:0];
            16'hBFFC: return m_snap;
            default:  return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_time = 0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_snap = 0;
        m_msip = 0; m_irq = 0; m_pre = 0;
    endtask

    // One clock of the model, from the register rules.
    task automatic m_step(input logic [31:0] a, input logic r, input logic w, input logic [31:0] d);
        bit tick, tw;
        logic [15:0] o;
        o    = offs(a);
        tick = (m_pre == P - 1);
        tw   = 0;
        m_irq = (m_time >= m_cmp);
        if (r && o == 16'hBFF8) m_snap = m_time[63:32];
        if (w) begin
            case (o)
                16'h0000: m_msip = d[0];
                16'h4000: m_cmp  = {m_cmp[63:32], d};
                16'h4004: m_cmp  = {d, m_cmp[31:0]};
                16'hBFF8: begin m_time = {m_time[63:32], d}; tw = 1; end
                16'hBFFC: begin m_time = {d, m_time[31:0]}; m_snap = d; tw = 1; end
                default: ;
            endcase
        end
        if (tick && !tw) m_time = m_time + 1;   // wraps naturally at 2^64
        m_pre = tick ? 0 : m_pre + 1;
    endtask

    // Called at posedge+1: drive, check pre-edge outputs, clock, update model.
    task automatic cyc(input logic [15:0] o, input logic r, input logic w, input logic [31:0] d);
        addr = START + {16'd0, o}; ren = r; wen = w; din = d;
        #1;
        check("data_out", dout, m_read(addr));
        check("timer_irq", tirq, m_irq);
        check("soft_irq", sirq, m_msip);
        @(posedge clk);
        m_step(addr, r, w, d);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(16'hBFF8, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic wr(input logic [15:0] o, input logic [31:0] d);
        cyc(o, 1'b0, 1'b1, d);
    endtask

    // Idle until the next edge is a tick edge (bounded).
    task automatic to_tick_cycle();
        for (int i = 0; i < 2 * P && m_pre != P - 1; i++) idle(1);
    endtask

    initial begin
        logic [15:0] offtab [7];
        offtab = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h0008, 16'h1234};

        rst_n = 1'b0; addr = START + 32'h4000; ren = 0; wen = 0; din = 0;
        m_reset();
        #12;
        check("rst_cmp_lo", dout, 32'hFFFF_FFFF);
        check("rst_tirq", tirq, 1'b0);
        check("rst_sirq", sirq, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Free run: 40 edges at PRESCALE=4 gives 10 ticks.
        idle(40);
        addr = START + 32'hBFF8; #1;
        check("mtime_after40", dout, 32'd10);
        check("cmp_lo_reset", m_read(START + 32'h4000) == 32'hFFFF_FFFF ? dout : 32'h0, 32'd10);

        // Timer interrupt rise and fall.
        wr(16'hBFF8, 32'd0);
        wr(16'h4004, 32'd0);
        wr(16'h4000, 32'd5);
        for (int i = 0; i < 40 && m_time < 5; i++) idle(1);
        check("irq_not_yet", tirq, 1'b0);
        idle(1);
        check("irq_rise", tirq, 1'b1);
        wr(16'h4000, 32'hFFFF_FFFF);
        check("irq_still_1", tirq, 1'b1);
        idle(1);
        check("irq_fall", tirq, 1'b0);
        wr(16'h4004, 32'hFFFF_FFFF);

        // 32-bit carry into the high word.
        wr(16'hBFF8, 32'hFFFF_FFFF);
        wr(16'hBFFC, 32'd0);
        for (int i = 0; i < 2 * P && m_time[63:32] == 0; i++) idle(1);
        cyc(16'hBFF8, 1'b1, 1'b0, 32'd0);
        cyc(16'hBFFC, 1'b1, 1'b0, 32'd0);
        addr = START + 32'hBFFC; #1;
        check("carry_hi", dout, 32'd1);

        // Snapshot: lo read just before rollover, hi read after.
        wr(16'hBFFC, 32'd1);
        wr(16'hBFF8, 32'hFFFF_FFFF);
        to_tick_cycle();
        cyc(16'hBFF8, 1'b1, 1'b0, 32'd0);
        addr = START + 32'hBFFC; #1;
        check("snap_hi", dout, 32'd1);
        check("model_hi_rolled", m_time[63:32], 64'd2);

        // Write beats tick.
        to_tick_cycle();
        wr(16'hBFF8, 32'h100);
        addr = START + 32'hBFF8; #1;
        check("wr_beats_tick", dout, 32'h100);

        // msip and unmapped offset.
        wr(16'h0000, 32'd1);
        check("sirq_set", sirq, 1'b1);
        addr = START; #1;
        check("msip_rd", dout, 32'd1);
        wr(16'h0000, 32'hFFFF_FFFE);
        check("sirq_clr", sirq, 1'b0);
        wr(16'h0008, 32'hDEAD_BEEF);
        addr = START + 32'h0008; #1;
        check("unmapped_rd", dout, 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [15:0] o;
            logic [31:0] d;
            logic        r, w;
            o = offtab[$urandom_range(0, 6)];
            r = 1'($urandom_range(0, 1));
            w = ($urandom_range(0, 3) == 0);
            d = $urandom;
            if (o == 16'h4000) d = m_time[31:0] + $urandom_range(0, 12);
            if (o == 16'h4004 || o == 16'hBFFC) d = ($urandom_range(0, 3) == 0) ? d : m_time[63:32];
            if (o == 16'hBFF8 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFFF - $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) begin
                // Bits above the decoded 16 must not affect the access.
                addr = START + {16'($urandom_range(1, 255)), o};
                ren = r; wen = w; din = d;
                #1;
                check("hi_addr_rd", dout, m_read(addr));
                @(posedge clk);
                m_step(addr, r, w, d);
                #1;
            end else begin
                cyc(o, r, w, d);
            end
        end

        // Async reset mid-count with both interrupts pending.
        wr(16'h0000, 32'd1);
        wr(16'h4004, 32'd0);
        wr(16'h4000, 32'd0);
        idle(2);
        check("pre_rst_tirq", tirq, 1'b1);
        check("pre_rst_sirq", sirq, 1'b1);
        addr = START + 32'h4000;
        rst_n = 1'b0;
        #1;
        m_reset();
        check("async_tirq", tirq, 1'b0);
        check("async_sirq", sirq, 1'b0);
        check("async_cmp", dout, 32'hFFFF_FFFF);
        addr = START + 32'hBFF8; #1;
        check("async_mtime", dout, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2 * P + 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
